// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder: one shared full-add cell sequenced over WIDTH cycles

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    logic ha0_s;
    logic ha0_c;
    logic fa_s;
    logic ha1_c;
    logic fa_c;

    // full add = two half adders, carries ORed
    half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(fa_s),  .c(ha1_c));
    assign fa_c = ha0_c | ha1_c;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    // the result register alone is not yet complete on this edge
                    if (last_bit) begin
                        sum  <= {fa_s, res_sr[WIDTH-1:1]};
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, captured on start acceptance.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, captured on start acceptance.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum and cout valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits: registered result of a+b, modulo 2^WIDTH.
REQ-010 The block SHALL have port cout, output, 1 bit: registered carry-out of the addition.

Function
REQ-011 The block SHALL sequence one shared 1-bit full-add datapath, built from two half-adder instances plus an OR of their carries, over WIDTH cycles per addition.
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL load a and b into shift registers, clear the carry flop and bit counter, and enter ADD.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE and hold sum and cout.
REQ-015 Each ADD edge SHALL add the operand LSBs and the carry flop, shift the sum bit into the result register MSB, shift the operands right, update the carry flop and increment the counter.
REQ-016 The block SHALL leave ADD for DONE on the edge that processes bit WIDTH-1, i.e. the WIDTH-th ADD edge.
REQ-017 On entering DONE, the block SHALL load the completed result onto sum and the final carry onto cout.
REQ-018 The block SHALL assert done only in DONE, for exactly one cycle, and then return to IDLE unconditionally.
REQ-019 Latency SHALL be fixed: done high in the cycle following the WIDTH-th edge after the start-sampling edge (8 cycles for WIDTH=8).
REQ-020 The block SHALL ignore start while in ADD or DONE, without queuing it.
REQ-021 Changes on a and b after acceptance SHALL NOT affect the result in progress.
REQ-022 The block SHALL hold sum and cout stable from DONE until the next DONE, including while a later addition is in progress.
REQ-023 Back-to-back operation SHALL be supported: start=1 in the IDLE cycle immediately after DONE is accepted, giving one idle cycle between done pulses.

Reset
REQ-024 rst_n=0 SHALL force, asynchronously, state=IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0 and operand registers=0.
REQ-025 Reset asserted mid-ADD or in DONE SHALL abort the operation without producing a done pulse.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 Basic add: WIDTH=8, a=8'h0F, b=8'h01, start pulsed -> busy high for 9 cycles, done pulse 8 cycles after acceptance, sum=8'h10, cout=0.
REQ-028 Overflow: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
REQ-029 Ignored start and operand changes: start held high and a/b changed every cycle during ADD -> exactly one done pulse, and the result matches the operands captured at acceptance.
REQ-030 Reset mid-operation: rst_n low at the 4th ADD cycle -> outputs 0 immediately, no done pulse; the next add 8'h12+8'h34 -> sum=8'h46.
REQ-031 Back-to-back: 8'h80+8'h80, then 8'h01+8'h02 started in the cycle after done -> results 8'h00/cout=1, then 8'h03/cout=0; the first result is held on sum during the second add.
REQ-032 Random: 1000 random operand pairs, with random start gaps including zero -> every sum/cout equals {cout,sum}=a+b.
